// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one single-ported multi-cycle memory between instruction fetch and data load/store
// Ports:
//   clk, reset (async, active-low)
//   if_req/if_addr in, if_rdata/if_ready out        fetch port, one-cycle ready pulse
//   d_rd/d_wr/d_addr/d_wdata in, d_rdata/d_ready out load/store port, one-cycle ready pulse
//   mem_en/mem_we/mem_addr/mem_wdata out, mem_rdata in  memory side, rdata valid in last busy cycle
//   err out                                          sticky: load and store requested together at grant
module mem_port_arbiter #(
    parameter int MEM_LAT    = 2,
    parameter int STARVE_MAX = 3,
    parameter int AW         = 32,
    parameter int DW         = 32
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          if_req,
    input  logic [AW-1:0] if_addr,
    output logic [DW-1:0] if_rdata,
    output logic          if_ready,
    input  logic          d_rd,
    input  logic          d_wr,
    input  logic [AW-1:0] d_addr,
    input  logic [DW-1:0] d_wdata,
    output logic [DW-1:0] d_rdata,
    output logic          d_ready,
    output logic          mem_en,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata,
    output logic          err
);
    localparam int CW = MEM_LAT > 1 ? $clog2(MEM_LAT) : 1;
    localparam int SW = STARVE_MAX > 0 ? $clog2(STARVE_MAX + 1) : 1;
    localparam logic [CW-1:0] LAT_M1 = CW'(MEM_LAT - 1);
    localparam logic [SW-1:0] SMAX   = SW'(STARVE_MAX);

    typedef enum logic [2:0] {IDLE, BUSY_I, BUSY_D, RESP_I, RESP_D} state_t;

    state_t        state, state_n;
    logic [CW-1:0] cnt;
    logic [SW-1:0] streak;
    logic          wr;
    logic          d_req, fetch_win, grant_i, grant_d, last;

    // Fetch wins when it is alone, or when data has already won STARVE_MAX ties in a row.
    always_comb begin
        d_req     = d_rd | d_wr;
        fetch_win = if_req && (!d_req || (STARVE_MAX != 0 && streak == SMAX));
        grant_i   = state == IDLE && fetch_win;
        grant_d   = state == IDLE && d_req && !fetch_win;
        last      = cnt == '0;
        state_n   = state;
        case (state)
            IDLE:    state_n = grant_i ? BUSY_I : grant_d ? BUSY_D : IDLE;
            BUSY_I:  state_n = last ? RESP_I : BUSY_I;
            BUSY_D:  state_n = last ? RESP_D : BUSY_D;
            default: state_n = IDLE;
        endcase
    end

    assign mem_en   = state == BUSY_I || state == BUSY_D;
    assign mem_we   = state == BUSY_D && wr;
    assign if_ready = state == RESP_I;
    assign d_ready  = state == RESP_D;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            cnt       <= '0;
            streak    <= '0;
            wr        <= 1'b0;
            err       <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            if_rdata  <= '0;
            d_rdata   <= '0;
        end else begin
            state <= state_n;
            if (grant_i || grant_d) begin
                cnt       <= LAT_M1;
                mem_addr  <= grant_i ? if_addr : d_addr;
                mem_wdata <= grant_d ? d_wdata : mem_wdata;
                wr        <= grant_d && d_wr;
            end else if (mem_en && !last) begin
                cnt <= cnt - 1'b1;
            end
            // Streak only counts data wins that actually held fetch off.
            if (grant_i)
                streak <= '0;
            else if (grant_d && if_req && STARVE_MAX != 0)
                streak <= streak + 1'b1;
            if (grant_d && d_rd && d_wr)
                err <= 1'b1;
            if (state == BUSY_I && last)
                if_rdata <= mem_rdata;
            if (state == BUSY_D && last && !wr)
                d_rdata <= mem_rdata;
        end
    end
endmodule
